// File: rtl/pagetable_ctrl.sv
// pagetable_ctrl: valid/ready front-end that sequences page-table RAM reads and strobed writes.
// Define PT_TLB_EN to add a single-entry translation cache in front of the RAM.
module pagetable_ctrl #(
    parameter int PTB_W = 5,
    parameter int VPN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_store,
    input  logic [PTB_W-1:0] req_ptb,
    input  logic [VPN_W-1:0] req_vpn,
    input  logic [7:0]       req_wdata,
    input  logic             tlb_flush,
    output logic             rsp_valid,
    output logic [5:0]       rsp_pfn,
    output logic             rsp_fault_np,
    output logic             rsp_fault_wp,
    output logic             pt_ce_n,
    output logic             pt_oe_n,
    output logic             pt_we_n,
    output logic [12:0]      pt_address,
    output logic [7:0]       pt_data_out,
    input  logic [7:0]       pt_data_in
);
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, RESP} state_t;
    state_t state, state_nx;
    logic store_q, rsp_ld, hit, wr_rsp, st, np_nx, wp_nx;
    logic [7:0] tlb_entry, ent;
    logic [5:0] pfn_nx;
    logic accept;
    assign accept = state == IDLE && req_valid;
    // Strobes come straight from the registered state so reset drops them at once.
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign pt_ce_n   = !(state inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
    assign pt_oe_n   = state != RD;
    assign pt_we_n   = state != WR_PULSE;
`ifdef PT_TLB_EN
    logic [12:0] tlb_tag;
    logic        tlb_valid;
    assign hit = tlb_valid && tlb_tag == {req_ptb, req_vpn};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlb_valid <= 1'b0;
            tlb_tag   <= '0;
            tlb_entry <= '0;
        end else begin
            if (state == RD) begin
                tlb_tag   <= pt_address;
                tlb_entry <= pt_data_in;
            end else if (accept && req_write && tlb_tag == {req_ptb, req_vpn})
                tlb_entry <= req_wdata;
            tlb_valid <= !tlb_flush && (tlb_valid || state == RD);
        end
    end
`else
    logic unused_flush;
    assign unused_flush = tlb_flush;
    assign hit = 1'b0;
    assign tlb_entry = '0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (req_valid) state_nx = req_write ? WR_SETUP : (hit ? RESP : RD);
            RD:       state_nx = RESP;
            WR_SETUP: state_nx = WR_PULSE;
            WR_PULSE: state_nx = WR_HOLD;
            WR_HOLD:  state_nx = RESP;
            default:  state_nx = IDLE;
        endcase
        rsp_ld = state_nx == RESP && state != RESP;
        wr_rsp = state == WR_HOLD;
        ent    = state == IDLE ? tlb_entry : pt_data_in;
        st     = state == IDLE ? req_store : store_q;
        np_nx  = !wr_rsp && !ent[7];
        wp_nx  = !wr_rsp && ent[7] && st && !ent[6];
        pfn_nx = wr_rsp ? pt_data_out[5:0] : (np_nx || wp_nx) ? 6'd0 : ent[5:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pt_address   <= '0;
            pt_data_out  <= '0;
            store_q      <= 1'b0;
            rsp_pfn      <= '0;
            rsp_fault_np <= 1'b0;
            rsp_fault_wp <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                pt_address  <= {req_ptb, req_vpn};
                pt_data_out <= req_wdata;
                store_q     <= req_store;
            end
            if (rsp_ld) begin
                rsp_pfn      <= pfn_nx;
                rsp_fault_np <= np_nx;
                rsp_fault_wp <= wp_nx;
            end
        end
    end
endmodule

// File: tb/tb_pagetable_ctrl.sv
// tb_pagetable_ctrl: directed plus random requests against a RAM model and a page-table reference.
module tb_pagetable_ctrl;
`ifdef PT_TLB_EN
    localparam bit TLB = 1'b1;
`else
    localparam bit TLB = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic req_valid = 1'b0, req_write = 1'b0, req_store = 1'b0, tlb_flush = 1'b0;
    logic [4:0] req_ptb = '0;
    logic [7:0] req_vpn = '0, req_wdata = '0;
    logic req_ready, rsp_valid, rsp_fault_np, rsp_fault_wp, pt_ce_n, pt_oe_n, pt_we_n;
    logic [5:0] rsp_pfn;
    logic [12:0] pt_address;
    logic [7:0] pt_data_out, pt_data_in;
    logic [7:0] ram [8192] = '{default: 8'h00};
    logic [7:0] ref_pt [8192];
    bit tv = 1'b0;
    logic [12:0] tt = '0;
    int n_assert = 0, n_fail = 0;

    pagetable_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_store(req_store), .req_ptb(req_ptb), .req_vpn(req_vpn),
        .req_wdata(req_wdata), .tlb_flush(tlb_flush), .rsp_valid(rsp_valid), .rsp_pfn(rsp_pfn),
        .rsp_fault_np(rsp_fault_np), .rsp_fault_wp(rsp_fault_wp), .pt_ce_n(pt_ce_n),
        .pt_oe_n(pt_oe_n), .pt_we_n(pt_we_n), .pt_address(pt_address),
        .pt_data_out(pt_data_out), .pt_data_in(pt_data_in)
    );

    // RAM: asynchronous read while selected, write sampled while ce_n and we_n are both low.
    assign pt_data_in = (!pt_ce_n && !pt_oe_n) ? ram[pt_address] : 8'hEE;
    always @(posedge clk) if (!pt_ce_n && !pt_we_n) ram[pt_address] <= pt_data_out;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input bit wr, input bit st, input logic [4:0] ptb, input logic [7:0] vpn, input logic [7:0] wd);
        logic [12:0] a;
        logic [7:0] e;
        logic [5:0] pfn;
        logic [2:0] stb;
        bit np, wp, hit;
        int lat;
        a = {ptb, vpn};
        hit = !wr && TLB && tv && tt == a;
        if (wr) begin
            pfn = wd[5:0]; np = 1'b0; wp = 1'b0; lat = 4;
            ref_pt[a] = wd;
        end else begin
            e = ref_pt[a];
            np = !e[7];
            wp = e[7] && st && !e[6];
            pfn = (np || wp) ? 6'd0 : e[5:0];
            lat = hit ? 1 : 2;
            if (!hit) begin tt = a; tv = 1'b1; end
        end
        @(negedge clk);
        chk("ready_idle", 16'(req_ready), 16'd1);
        req_valid = 1'b1; req_write = wr; req_store = st; req_ptb = ptb; req_vpn = vpn; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c == lat) stb = 3'b111;
            else if (!wr) stb = 3'b001;
            else stb = (c == 2) ? 3'b010 : 3'b011;
            chk("strobes_ce_oe_we", 16'({pt_ce_n, pt_oe_n, pt_we_n}), 16'(stb));
            chk("rsp_valid", 16'(rsp_valid), 16'(c == lat));
            chk("ready_busy", 16'(req_ready), 16'd0);
            chk("address", 16'(pt_address), 16'(a));
            chk("data_out", 16'(pt_data_out), 16'(wd));
            if (c < lat) begin @(posedge clk); #1; end
        end
        chk("rsp_pfn", 16'(rsp_pfn), 16'(pfn));
        chk("fault_np", 16'(rsp_fault_np), 16'(np));
        chk("fault_wp", 16'(rsp_fault_wp), 16'(wp));
        @(posedge clk); #1;
        chk("ready_after", 16'(req_ready), 16'd1);
        chk("rsp_pulse_end", 16'(rsp_valid), 16'd0);
        chk("rsp_pfn_hold", 16'(rsp_pfn), 16'(pfn));
    endtask

    task automatic flush();
        @(negedge clk); tlb_flush = 1'b1;
        @(negedge clk); tlb_flush = 1'b0;
        tv = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ref_pt[i] = 8'h00;
        #12;
        chk("rst_ready", 16'(req_ready), 16'd1);
        chk("rst_strobes", 16'({pt_ce_n, pt_oe_n, pt_we_n}), 16'h7);
        chk("rst_address", 16'(pt_address), 16'd0);
        chk("rst_data_out", 16'(pt_data_out), 16'd0);
        chk("rst_rsp", 16'({rsp_valid, rsp_pfn, rsp_fault_np, rsp_fault_wp}), 16'd0);
        @(negedge clk); rst_n = 1'b1;
        do_req(1'b1, 1'b0, 5'd3, 8'h12, 8'hC5);
        do_req(1'b0, 1'b1, 5'd3, 8'h12, 8'h00);
        do_req(1'b1, 1'b0, 5'd3, 8'h12, 8'h85);
        do_req(1'b0, 1'b1, 5'd3, 8'h12, 8'h00);
        do_req(1'b0, 1'b0, 5'd3, 8'h12, 8'h00);
        do_req(1'b0, 1'b0, 5'd31, 8'hFF, 8'h00);
        do_req(1'b0, 1'b0, 5'd31, 8'hFF, 8'h00);
        flush();
        do_req(1'b0, 1'b0, 5'd31, 8'hFF, 8'h00);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) flush();
            do_req($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 1)),
                   8'($urandom_range(0, 3)), 8'($urandom));
        end
        // Reset in the middle of the write pulse.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_store = 1'b0; req_ptb = 5'd7; req_vpn = 8'h40; req_wdata = 8'hE1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_we_low", 16'(pt_we_n), 16'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", 16'({pt_ce_n, pt_oe_n, pt_we_n}), 16'h7);
        chk("mid_rst_rsp_valid", 16'(rsp_valid), 16'd0);
        repeat (2) @(posedge clk);
        #1 chk("mid_rst_no_rsp", 16'(rsp_valid), 16'd0);
        @(negedge clk); rst_n = 1'b1;
        tv = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 16'(req_ready), 16'd1);
        chk("post_rst_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("post_rst_pfn", 16'(rsp_pfn), 16'd0);
        do_req(1'b1, 1'b0, 5'd7, 8'h40, 8'hE1);
        do_req(1'b1, 1'b0, 5'd0, 8'h00, 8'h9A);
        do_req(1'b0, 1'b1, 5'd7, 8'h40, 8'h00);
        do_req(1'b0, 1'b1, 5'd0, 8'h00, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
